// File: rtl/trigger_pulse_recover.sv
// Turns an arbitrary-width, already-synchronized trigger level into one single-cycle event
// pulse per qualified assertion, with glitch filtering, re-trigger holdoff and event/drop counters.
module trigger_pulse_recover #(
  parameter int FILTER_CYCLES  = 4,
  parameter int HOLDOFF_CYCLES = 8,
  parameter int COUNT_WIDTH    = 32,
  parameter int DROP_WIDTH     = 16
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   level_in,
  input  logic                   counters_clear,
  output logic                   pulse,
  output logic                   busy,
  output logic [COUNT_WIDTH-1:0] event_count,
  output logic [DROP_WIDTH-1:0]  dropped_count
);

  localparam int FW = $clog2(FILTER_CYCLES) + 1;
  localparam int HW = $clog2(HOLDOFF_CYCLES) + 1;
  localparam logic [FW-1:0] F_LAST = FW'(FILTER_CYCLES - 1);
  localparam logic [HW-1:0] H_LAST = HW'(HOLDOFF_CYCLES);

  typedef enum logic [1:0] {IDLE, QUALIFY, WAIT_LOW, HOLDOFF} state_t;

  state_t          state, state_nxt;
  logic [FW-1:0]   fcnt, fcnt_nxt;
  logic [HW-1:0]   hcnt, hcnt_nxt;
  logic            prev;
  logic            rise;
  logic            fire;
  logic            drop;

  function automatic logic [DROP_WIDTH-1:0] sat_inc(input logic [DROP_WIDTH-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

  assign rise = level_in & ~prev;
  assign busy = (state != IDLE);

  always_comb begin
    state_nxt = state;
    fcnt_nxt  = fcnt;
    hcnt_nxt  = hcnt;
    fire      = 1'b0;
    drop      = 1'b0;
    case (state)
      IDLE: begin
        if (rise) begin
          if (FILTER_CYCLES == 1) begin
            fire      = 1'b1;
            state_nxt = WAIT_LOW;
          end else begin
            state_nxt = QUALIFY;
            fcnt_nxt  = FW'(1);
          end
        end
      end
      QUALIFY: begin
        if (!level_in) begin
          state_nxt = IDLE;
          fcnt_nxt  = '0;
        end else if (fcnt == F_LAST) begin
          fire      = 1'b1;
          state_nxt = WAIT_LOW;
          fcnt_nxt  = '0;
        end else begin
          fcnt_nxt = fcnt + 1'b1;
        end
      end
      WAIT_LOW: begin
        if (!level_in) begin
          state_nxt = HOLDOFF;
          hcnt_nxt  = HW'(1);
        end
      end
      HOLDOFF: begin
        drop = rise;
        // A level still high at expiry is treated as the same assertion, not a new one.
        if (hcnt == H_LAST) begin
          hcnt_nxt  = '0;
          state_nxt = level_in ? WAIT_LOW : IDLE;
        end else begin
          hcnt_nxt = hcnt + 1'b1;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state         <= IDLE;
      fcnt          <= '0;
      hcnt          <= '0;
      prev          <= 1'b1;
      pulse         <= 1'b0;
      event_count   <= '0;
      dropped_count <= '0;
    end else begin
      state <= state_nxt;
      fcnt  <= fcnt_nxt;
      hcnt  <= hcnt_nxt;
      prev  <= level_in;
      pulse <= fire;
      if (counters_clear) begin
        event_count   <= '0;
        dropped_count <= '0;
      end else begin
        if (fire) event_count <= event_count + 1'b1;
        if (drop) dropped_count <= sat_inc(dropped_count);
      end
    end
  end

endmodule

// File: tb/tb_trigger_pulse_recover.sv
// Directed bench for trigger_pulse_recover: default instance plus a DROP_WIDTH=2 instance
// sharing the same stimulus to exercise drop-counter saturation.
module tb_trigger_pulse_recover;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        level_in;
  logic        counters_clear;
  logic        pulse, busy;
  logic [31:0] event_count;
  logic [15:0] dropped_count;
  logic        pulse_s, busy_s;
  logic [31:0] event_count_s;
  logic [1:0]  dropped_count_s;

  int total = 0;
  int passed = 0;
  int fails = 0;
  int npulse = 0;

  always #5 clk = ~clk;

  trigger_pulse_recover u_dut (
    .clk(clk), .rst_n(rst_n), .level_in(level_in), .counters_clear(counters_clear),
    .pulse(pulse), .busy(busy), .event_count(event_count), .dropped_count(dropped_count)
  );

  trigger_pulse_recover #(.DROP_WIDTH(2)) u_sat (
    .clk(clk), .rst_n(rst_n), .level_in(level_in), .counters_clear(counters_clear),
    .pulse(pulse_s), .busy(busy_s), .event_count(event_count_s), .dropped_count(dropped_count_s)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      fails++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Advance n clock edges; inputs change and outputs are sampled 1 time unit after each edge.
  task automatic run(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
      npulse += int'(pulse);
    end
  endtask

  initial begin
    rst_n = 1'b0; level_in = 1'b0; counters_clear = 1'b0;
    run(2);
    chk("rst_pulse", pulse, 0);
    chk("rst_busy", busy, 0);
    chk("rst_event", event_count, 0);
    chk("rst_drop", dropped_count, 0);
    chk("rst_drop_s", dropped_count_s, 0);
    rst_n = 1'b1;
    run(1);

    // 10-cycle high: pulse on the 4th edge, holdoff ends 8 cycles after the low sample
    npulse = 0;
    level_in = 1'b1;
    run(1);
    chk("t1_busy_qual", busy, 1);
    run(2);
    chk("t1_pulse_early", pulse, 0);
    run(1);
    chk("t1_pulse", pulse, 1);
    chk("t1_event", event_count, 1);
    run(1);
    chk("t1_pulse_width", pulse, 0);
    run(5);
    level_in = 1'b0;
    run(1);
    chk("t1_busy_hold", busy, 1);
    run(7);
    chk("t1_busy_hold_last", busy, 1);
    run(1);
    chk("t1_busy_idle", busy, 0);
    chk("t1_npulse", npulse, 1);

    // 3-cycle glitch discarded
    npulse = 0;
    level_in = 1'b1;
    run(3);
    level_in = 1'b0;
    run(1);
    chk("t2_busy", busy, 0);
    chk("t2_npulse", npulse, 0);
    chk("t2_event", event_count, 1);
    chk("t2_drop", dropped_count, 0);

    // long level gives exactly one pulse
    level_in = 1'b1;
    run(1000);
    chk("t3_npulse", npulse, 1);
    chk("t3_event", event_count, 2);
    level_in = 1'b0;
    run(9);
    chk("t3_busy", busy, 0);

    // two 1-cycle highs during holdoff are dropped
    npulse = 0;
    level_in = 1'b1;
    run(4);
    chk("t4_pulse", pulse, 1);
    level_in = 1'b0;
    run(2);
    level_in = 1'b1;
    run(1);
    level_in = 1'b0;
    run(2);
    level_in = 1'b1;
    run(1);
    level_in = 1'b0;
    run(3);
    chk("t4_busy", busy, 0);
    chk("t4_drop", dropped_count, 2);
    chk("t4_drop_s", dropped_count_s, 2);
    chk("t4_npulse", npulse, 1);
    run(3);
    npulse = 0;
    level_in = 1'b1;
    run(4);
    chk("t4_pulse2", pulse, 1);
    chk("t4_event", event_count, 4);
    run(1);
    level_in = 1'b0;
    run(9);
    chk("t4_busy2", busy, 0);
    chk("t4_npulse2", npulse, 1);

    // four more drops: 16-bit counter reaches 6, 2-bit counter saturates at 3
    level_in = 1'b1;
    run(4);
    level_in = 1'b0;
    run(1);
    for (int i = 0; i < 4; i++) begin
      level_in = 1'b1;
      run(1);
      level_in = 1'b0;
      run(1);
    end
    chk("t5_busy", busy, 0);
    chk("t5_drop", dropped_count, 6);
    chk("t5_drop_sat", dropped_count_s, 3);
    chk("t5_event", event_count, 5);

    // clear coincident with a pulse: pulse still issued, counters zero
    level_in = 1'b1;
    run(3);
    counters_clear = 1'b1;
    run(1);
    counters_clear = 1'b0;
    chk("t5_clr_pulse", pulse, 1);
    chk("t5_clr_event", event_count, 0);
    chk("t5_clr_drop", dropped_count, 0);
    chk("t5_clr_drop_s", dropped_count_s, 0);
    run(1);
    chk("t5_clr_pulse_off", pulse, 0);
    chk("t5_clr_event2", event_count, 0);
    chk("t5_clr_busy", busy, 1);
    level_in = 1'b0;
    run(9);
    chk("t5_busy_end", busy, 0);

    // level held high through reset release never fires
    rst_n = 1'b0;
    level_in = 1'b1;
    run(2);
    chk("t6_rst_busy", busy, 0);
    chk("t6_rst_event", event_count, 0);
    rst_n = 1'b1;
    npulse = 0;
    run(6);
    chk("t6_npulse", npulse, 0);
    chk("t6_busy", busy, 0);
    level_in = 1'b0;
    run(1);
    level_in = 1'b1;
    run(4);
    chk("t6_pulse", pulse, 1);
    chk("t6_event", event_count, 1);
    level_in = 1'b0;
    run(9);

    // reset in the middle of qualification
    level_in = 1'b1;
    run(2);
    chk("t6_mid_busy", busy, 1);
    rst_n = 1'b0;
    run(1);
    chk("t6_mid_pulse", pulse, 0);
    chk("t6_mid_busy_rst", busy, 0);
    chk("t6_mid_event", event_count, 0);
    chk("t6_mid_drop", dropped_count, 0);
    rst_n = 1'b1;
    npulse = 0;
    run(6);
    chk("t6_mid_npulse", npulse, 0);
    chk("t6_mid_busy_end", busy, 0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/trigger_pulse_recover.md
Name: trigger_pulse_recover

Overview:
- Converts a slow or arbitrary-width trigger level into exactly one single-cycle event pulse per qualified assertion. It is the inverse of the LED pulse stretcher.
- Sits after the input synchronizer on each trigger input channel. Feeds the crossbar event fabric and the per-channel statistics counters.
- Provides a glitch filter (minimum high width), re-trigger holdoff after each release, and event/drop counters.

Parameters:
- FILTER_CYCLES, 4, consecutive high samples required to qualify an assertion; legal range >=1.
- HOLDOFF_CYCLES, 8, cycles after release during which new rising edges are rejected; legal range >=1.
- COUNT_WIDTH, 32, width of event_count; wraps on overflow.
- DROP_WIDTH, 16, width of dropped_count; saturates.

Ports:
- clk  in  1  single clock.
- rst_n  in  1  synchronous active-low reset.
- level_in  in  1  trigger level, already synchronized to clk.
- counters_clear  in  1  synchronous clear of both counters.
- pulse  out  1  registered single-cycle event strobe.
- busy  out  1  high whenever state != IDLE.
- event_count  out  COUNT_WIDTH  number of pulses emitted.
- dropped_count  out  DROP_WIDTH  rising edges rejected during holdoff.

Behaviour:
- Reset: one clock, synchronous, active-low. While rst_n=0 at a clk edge:
  - state=IDLE, pulse=0, busy=0, event_count=0, dropped_count=0, filter/holdoff counters=0.
  - Previous-sample register prev=1, so a level held high across reset release never fires.
- Reset mid-operation aborts any qualify/holdoff immediately; no pulse is issued in the reset cycle or the cycle after.
- prev <= level_in every non-reset cycle. rise = level_in & ~prev.
- States:
  - IDLE: on rise, go to QUALIFY with fcnt=1.
    - If FILTER_CYCLES=1, instead emit the pulse and go directly to WAIT_LOW.
  - QUALIFY:
    - level_in=0: return to IDLE; no pulse, no count change (glitch discarded).
    - level_in=1: fcnt++. When the FILTER_CYCLES-th consecutive high sample is taken, pulse<=1 for the next cycle only, event_count++, go to WAIT_LOW.
  - WAIT_LOW: level_in high is ignored; no further pulses regardless of duration. On level_in=0, go to HOLDOFF with hcnt=1.
  - HOLDOFF:
    - hcnt++ each cycle.
    - Each rise seen in HOLDOFF increments dropped_count, saturating at all-ones; no pulse.
    - When hcnt reaches HOLDOFF_CYCLES: if level_in=1 go to WAIT_LOW (no pulse, no drop count for the still-high level); else go to IDLE.
    - A rise on the expiry cycle itself is counted as dropped.
- Latency: first high sample at edge k. pulse is high during the cycle after edge k+FILTER_CYCLES-1, i.e. FILTER_CYCLES cycles after level_in is first sampled high. Width is exactly 1 cycle.
- Minimum spacing between pulses: FILTER_CYCLES + 1 (low sample) + HOLDOFF_CYCLES cycles.
- Counters:
  - event_count wraps modulo 2^COUNT_WIDTH.
  - dropped_count never wraps.
  - counters_clear=1 sets both counters to 0 on the next edge. Clear wins over a coincident increment.
  - Clear does not affect state, pulse, or busy.
- Width rules: fcnt and hcnt are sized to $clog2 of their parameter +1 and never overflow.

Test Plan:
- Defaults (F=4, H=8). Release reset with level_in=0; raise level_in for 10 cycles -> pulse high for exactly 1 cycle, 4 cycles after the first high sample; event_count=1; busy low again 8 cycles after level_in falls.
- level_in high for 3 cycles, then low -> no pulse, event_count=0, dropped_count=0, busy returns to 0 the cycle after the low sample.
- level_in held high for 1000 cycles -> exactly one pulse; event_count=1.
- After release, two 1-cycle highs at holdoff cycles 2 and 5 -> dropped_count=2, no pulse. A 5-cycle high starting 3 cycles after holdoff expiry -> one pulse, event_count=2.
- Set DROP_WIDTH=2 and generate 6 rejected edges -> dropped_count saturates at 3. Assert counters_clear coincident with a pulse -> pulse still issued, both counters read 0 on the next cycle.
- Hold level_in=1 through rst_n deassertion -> no pulse. Then level_in low for 1 cycle and high for 4 -> one pulse, event_count=1. Assert rst_n low mid-QUALIFY -> no pulse and all counters 0.
